video_pattern_gen: RTL and testbench

VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

---
 rtl/video_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_video_pattern_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Raster timing generator with four selectable test patterns.
// Sync, data-enable and pixel data are registered one clock behind the counters.
module video_pattern_gen #(
  parameter int HSW  = 1,
  parameter int HBP  = 2,
  parameter int HACT = 10,
  parameter int HFP  = 2,
  parameter int VSW  = 1,
  parameter int VBP  = 1,
  parameter int VACT = 4,
  parameter int VFP  = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_en,
  input  logic [1:0] i_pat_sel,
  output logic       o_vsync,
  output logic       o_hsync,
  output logic       o_de,
  output logic [9:0] o_r_data,
  output logic [9:0] o_g_data,
  output logic [9:0] o_b_data,
  output logic       o_frame_start
);

  localparam int HTOT   = HSW + HBP + HACT + HFP;
  localparam int VTOT   = VSW + VBP + VACT + VFP;
  localparam int HW     = $clog2(HTOT + 1);
  localparam int VW     = $clog2(VTOT + 1);
  localparam int HSTART = HSW + HBP;
  localparam int HEND   = HSTART + HACT;
  localparam int VSTART = VSW + VBP;
  localparam int VEND   = VSTART + VACT;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_MOTION  = 2'd3
  } pat_e;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [9:0]    frameCnt_q, frameCnt_d;
  pat_e          pat_q, pat_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          frameStart_q, frameStart_d;
  logic [9:0]    rData_q, rData_d;
  logic [9:0]    gData_q, gData_d;
  logic [9:0]    bData_q, bData_d;

  logic          hWrap, vWrap, firstPix, hAct, vAct;
  logic [9:0]    xPix, yPix;

  // Outputs are decoded from the counter values held before the edge, so a
  // disabled generator simply forces every output register to zero.
  always_comb begin
    hWrap    = (hcnt_q == HW'(HTOT - 1));
    vWrap    = (vcnt_q == VW'(VTOT - 1));
    firstPix = (hcnt_q == '0) && (vcnt_q == '0);
    hAct     = (hcnt_q >= HW'(HSTART)) && (hcnt_q < HW'(HEND));
    vAct     = (vcnt_q >= VW'(VSTART)) && (vcnt_q < VW'(VEND));
    xPix     = 10'(hcnt_q - HW'(HSTART));
    yPix     = 10'(vcnt_q - VW'(VSTART));

    hcnt_d       = '0;
    vcnt_d       = '0;
    frameCnt_d   = frameCnt_q;
    pat_d        = pat_q;
    hsync_d      = 1'b0;
    vsync_d      = 1'b0;
    de_d         = 1'b0;
    frameStart_d = 1'b0;
    rData_d      = '0;
    gData_d      = '0;
    bData_d      = '0;

    if (i_en) begin
      hcnt_d = hWrap ? '0 : hcnt_q + HW'(1);
      if (hWrap) begin
        vcnt_d = vWrap ? '0 : vcnt_q + VW'(1);
      end else begin
        vcnt_d = vcnt_q;
      end
      if (hWrap && vWrap) begin
        frameCnt_d = frameCnt_q + 10'd1;
      end
      // Pattern changes are only accepted on the first clock of a frame.
      if (firstPix) begin
        pat_d = pat_e'(i_pat_sel);
      end

      hsync_d      = (hcnt_q < HW'(HSW));
      vsync_d      = (vcnt_q < VW'(VSW));
      de_d         = hAct && vAct;
      frameStart_d = firstPix;

      if (de_d) begin
        case (pat_q)
          PAT_HRAMP: begin
            rData_d = xPix;
            gData_d = xPix;
            bData_d = xPix;
          end
          PAT_VRAMP: begin
            rData_d = yPix;
            gData_d = yPix;
            bData_d = yPix;
          end
          PAT_CHECKER: begin
            rData_d = {10{xPix[0] ^ yPix[0]}};
            gData_d = {10{xPix[0] ^ yPix[0]}};
            bData_d = {10{xPix[0] ^ yPix[0]}};
          end
          PAT_MOTION: begin
            rData_d = frameCnt_q;
            gData_d = xPix;
            bData_d = yPix;
          end
          default: begin
            rData_d = '0;
            gData_d = '0;
            bData_d = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      frameCnt_q   <= '0;
      pat_q        <= PAT_HRAMP;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      de_q         <= 1'b0;
      frameStart_q <= 1'b0;
      rData_q      <= '0;
      gData_q      <= '0;
      bData_q      <= '0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      frameCnt_q   <= frameCnt_d;
      pat_q        <= pat_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      de_q         <= de_d;
      frameStart_q <= frameStart_d;
      rData_q      <= rData_d;
      gData_q      <= gData_d;
      bData_q      <= bData_d;
    end
  end

  assign o_vsync       = vsync_q;
  assign o_hsync       = hsync_q;
  assign o_de          = de_q;
  assign o_frame_start = frameStart_q;
  assign o_r_data      = rData_q;
  assign o_g_data      = gData_q;
  assign o_b_data      = bData_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: default-timing instance plus a tiny
// 4x4 raster instance used to reach the frame counter rollover quickly.
module tb_video_pattern_gen;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [1:0] patSel;
  logic       vsync, hsync, de, frameStart;
  logic [9:0] rData, gData, bData;

  logic       enS;
  logic [1:0] patS;
  logic       vsyncS, hsyncS, deS, frameStartS;
  logic [9:0] rDataS, gDataS, bDataS;

  int errors;
  int checks;
  int edgeN;
  int deCnt, fsCnt, hsCnt, vsCnt, lineDe, nzCnt;

  video_pattern_gen dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_en          (en),
    .i_pat_sel     (patSel),
    .o_vsync       (vsync),
    .o_hsync       (hsync),
    .o_de          (de),
    .o_r_data      (rData),
    .o_g_data      (gData),
    .o_b_data      (bData),
    .o_frame_start (frameStart)
  );

  video_pattern_gen #(
    .HSW(1), .HBP(1), .HACT(1), .HFP(1),
    .VSW(1), .VBP(1), .VACT(1), .VFP(1)
  ) dutSmall (
    .clk           (clk),
    .rstn          (rstn),
    .i_en          (enS),
    .i_pat_sel     (patS),
    .o_vsync       (vsyncS),
    .o_hsync       (hsyncS),
    .o_de          (deS),
    .o_r_data      (rDataS),
    .o_g_data      (gDataS),
    .o_b_data      (bDataS),
    .o_frame_start (frameStartS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edgeN++;
  endtask

  task automatic applyStimulus(input logic rstnV, input logic enV, input logic [1:0] patV);
    rstn   = rstnV;
    en     = enV;
    patSel = patV;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic startRun(input logic [1:0] pat);
    applyStimulus(1'b0, 1'b0, pat);
    step();
    step();
    applyStimulus(1'b1, 1'b1, pat);
    edgeN = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    edgeN  = 0;
    enS    = 1'b0;
    patS   = 2'd3;

    // Reset state and default horizontal ramp timing
    $display("[TB] reset and pattern 0 timing");
    applyStimulus(1'b0, 1'b0, 2'd0);
    step();
    step();
    checkOutput("rst_hsync", hsync, 0);
    checkOutput("rst_vsync", vsync, 0);
    checkOutput("rst_de", de, 0);
    checkOutput("rst_fs", frameStart, 0);
    checkOutput("rst_r", rData, 0);
    applyStimulus(1'b1, 1'b1, 2'd0);
    edgeN = 0;
    deCnt = 0; fsCnt = 0; hsCnt = 0; vsCnt = 0; lineDe = 0;
    for (int n = 1; n <= 105; n++) begin
      step();
      deCnt += int'(de);
      fsCnt += int'(frameStart);
      hsCnt += int'(hsync);
      vsCnt += int'(vsync);
      if (n >= 31 && n <= 45) lineDe += int'(de);
      if (n == 1) begin
        checkOutput("e1_hsync", hsync, 1);
        checkOutput("e1_vsync", vsync, 1);
        checkOutput("e1_fs", frameStart, 1);
        checkOutput("e1_de", de, 0);
      end
      if (n == 2) checkOutput("e2_fs", frameStart, 0);
      if (n == 34) begin
        checkOutput("e34_de", de, 1);
        checkOutput("e34_r", rData, 0);
        checkOutput("e34_g", gData, 0);
        checkOutput("e34_b", bData, 0);
      end
      if (n == 43) begin
        checkOutput("e43_r", rData, 9);
        checkOutput("e43_g", gData, 9);
        checkOutput("e43_b", bData, 9);
      end
      if (n == 44) begin
        checkOutput("e44_de", de, 0);
        checkOutput("e44_r", rData, 0);
      end
    end
    checkOutput("frame_de_count", deCnt, 40);
    checkOutput("line_de_count", lineDe, 10);
    checkOutput("frame_fs_count", fsCnt, 1);
    checkOutput("frame_hsync_count", hsCnt, 7);
    checkOutput("frame_vsync_count", vsCnt, 15);
    step();
    checkOutput("e106_fs", frameStart, 1);
    checkOutput("e106_vsync", vsync, 1);

    // Checkerboard
    $display("[TB] pattern 2 checker");
    startRun(2'd2);
    for (int n = 1; n <= 60; n++) begin
      step();
      if (n == 1) begin
        checkOutput("chk_e1_fs", frameStart, 1);
        checkOutput("chk_e1_hsync", hsync, 1);
      end
      if (n >= 34 && n <= 43)
        checkOutput("chk_line0_r", rData, ((n - 34) % 2 == 1) ? 32'h3FF : 32'h0);
      if (n >= 49 && n <= 58)
        checkOutput("chk_line1_r", rData, ((n - 49) % 2 == 1) ? 32'h0 : 32'h3FF);
      if (n == 35) begin
        checkOutput("chk_e35_g", gData, 32'h3FF);
        checkOutput("chk_e35_b", bData, 32'h3FF);
      end
      if (n == 34) checkOutput("chk_e34_de", de, 1);
      if (n == 44) checkOutput("chk_e44_de", de, 0);
    end

    // Motion pattern over three frames
    $display("[TB] pattern 3 motion");
    startRun(2'd3);
    for (int n = 1; n <= 245; n++) begin
      step();
      if (n == 34)  checkOutput("mot_f0_r", rData, 0);
      if (n == 139) checkOutput("mot_f1_r", rData, 1);
      if (n == 244) checkOutput("mot_f2_r", rData, 2);
      if (n == 43) begin
        checkOutput("mot_e43_g", gData, 9);
        checkOutput("mot_e43_b", bData, 0);
      end
      if (n == 49) begin
        checkOutput("mot_e49_g", gData, 0);
        checkOutput("mot_e49_b", bData, 1);
      end
    end

    // Pattern change mid-frame takes effect at the next frame
    $display("[TB] pattern change mid-frame");
    startRun(2'd0);
    for (int n = 1; n <= 190; n++) begin
      if (n == 50) patSel = 2'd1;
      step();
      if (n == 50)  checkOutput("psel_e50_r", rData, 1);
      if (n == 58)  checkOutput("psel_e58_r", rData, 9);
      if (n == 139) checkOutput("psel_f1_first_r", rData, 0);
      if (n == 148) checkOutput("psel_f1_first_end_r", rData, 0);
      if (n == 154) checkOutput("psel_f1_line1_r", rData, 1);
      if (n == 184) checkOutput("psel_f1_last_r", rData, 3);
      if (n == 188) checkOutput("psel_f1_last_mid_r", rData, 3);
    end

    // Enable dropped then restored
    $display("[TB] enable toggle");
    startRun(2'd0);
    nzCnt = 0;
    for (int n = 1; n <= 105; n++) begin
      if (n == 41) en = 1'b0;
      if (n == 61) en = 1'b1;
      step();
      if (n == 40) begin
        checkOutput("en_e40_de", de, 1);
        checkOutput("en_e40_r", rData, 6);
      end
      if (n >= 41 && n <= 60)
        if (hsync || vsync || de || frameStart || rData != 0 || gData != 0 || bData != 0)
          nzCnt++;
      if (n == 61) begin
        checkOutput("en_e61_fs", frameStart, 1);
        checkOutput("en_e61_hsync", hsync, 1);
        checkOutput("en_e61_vsync", vsync, 1);
        checkOutput("en_e61_de", de, 0);
      end
      if (n == 94) begin
        checkOutput("en_e94_de", de, 1);
        checkOutput("en_e94_r", rData, 0);
      end
      if (n == 103) checkOutput("en_e103_r", rData, 9);
    end
    checkOutput("en_off_nonzero_cycles", nzCnt, 0);

    // Asynchronous reset mid-frame
    $display("[TB] reset mid-frame");
    startRun(2'd0);
    for (int n = 1; n <= 70; n++) begin
      step();
      if (n == 69) checkOutput("rst_e69_r", rData, 5);
      if (n == 70) checkOutput("rst_e70_de", de, 1);
    end
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_de", de, 0);
    checkOutput("rst_async_r", rData, 0);
    checkOutput("rst_async_vsync", vsync, 0);
    step();
    rstn = 1'b1;
    edgeN = 0;
    for (int n = 1; n <= 44; n++) begin
      step();
      if (n == 1) begin
        checkOutput("rel_e1_fs", frameStart, 1);
        checkOutput("rel_e1_hsync", hsync, 1);
        checkOutput("rel_e1_vsync", vsync, 1);
        checkOutput("rel_e1_de", de, 0);
      end
      if (n == 34) begin
        checkOutput("rel_e34_de", de, 1);
        checkOutput("rel_e34_r", rData, 0);
      end
      if (n == 43) checkOutput("rel_e43_r", rData, 9);
      if (n == 44) checkOutput("rel_e44_de", de, 0);
    end

    // Frame counter rollover on the 16-clock raster
    $display("[TB] frame counter rollover");
    en  = 1'b0;
    enS = 1'b1;
    for (int f = 0; f <= 1024; f++) begin
      for (int p = 0; p < 16; p++) begin
        step();
        if (p == 10 && (f == 1 || f == 1022 || f == 1023 || f == 1024)) begin
          checkOutput("wrap_de", deS, 1);
          checkOutput("wrap_r", rDataS, 32'(f % 1024));
        end
      end
    end
    enS = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
